// File: rtl/tl_slave_mem.sv
// Single-outstanding slave: A-channel put/get into a DEPTH x 32 register memory,
// fixed-latency D-channel response. Optional feature macro: TL_SLAVE_DENIED_EN.
module tl_slave_mem #(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [3:0]  a_opcode,
  input  logic [3:0]  a_mask,
  input  logic [3:0]  a_address,
  input  logic [31:0] a_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [3:0]  d_opcode,
  output logic [31:0] d_data,
  output logic        d_denied
);

  // state | meaning
  // IDLE  | waiting for an A request (a_ready high)
  // BUSY  | access latency countdown
  // RESP  | D response presented, held until d_ready
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] OP_FULL  = 4'd0;
  localparam logic [3:0] OP_PART  = 4'd1;
  localparam logic [3:0] OP_GET   = 4'd4;
  localparam logic [4:0] DEPTH_W  = 5'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [3:0]  idx_q;
  logic        den_q;
  logic [31:0] mem [16];

  logic [3:0]  a_idx;
  logic        a_known;
  logic        a_den;
  logic [3:0]  r_op;
  logic [3:0]  r_idx;
  logic        r_den;
  logic [31:0] r_data;

  assign a_ready = (state == IDLE);
  assign a_idx   = 4'({1'b0, a_address} % DEPTH_W);
  assign a_known = (a_opcode == OP_FULL) || (a_opcode == OP_PART) || (a_opcode == OP_GET);

`ifdef TL_SLAVE_DENIED_EN
  assign a_den = ({1'b0, a_address} >= DEPTH_W) || !a_known;
`else
  assign a_den = 1'b0;
`endif

  // With zero latency the response is built straight from the A inputs.
  assign r_op   = (state == IDLE) ? a_opcode : op_q;
  assign r_idx  = (state == IDLE) ? a_idx    : idx_q;
  assign r_den  = (state == IDLE) ? a_den    : den_q;
  assign r_data = ((r_op == OP_GET) && !r_den) ? mem[r_idx] : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_q     <= 4'd0;
      idx_q    <= 4'd0;
      den_q    <= 1'b0;
      d_valid  <= 1'b0;
      d_opcode <= 4'd0;
      d_data   <= 32'd0;
      d_denied <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid) begin
            op_q  <= a_opcode;
            idx_q <= a_idx;
            den_q <= a_den;
            if (!a_den) begin
              if (a_opcode == OP_FULL) begin
                mem[a_idx] <= a_data;
              end else if (a_opcode == OP_PART) begin
                for (int b = 0; b < 4; b++)
                  if (a_mask[b]) mem[a_idx][8*b +: 8] <= a_data[8*b +: 8];
              end
            end
            if (LATENCY == 0) begin
              state    <= RESP;
              d_valid  <= 1'b1;
              d_opcode <= (r_op == OP_GET) ? 4'd1 : 4'd0;
              d_data   <= r_data;
              d_denied <= r_den;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state    <= RESP;
            d_valid  <= 1'b1;
            d_opcode <= (r_op == OP_GET) ? 4'd1 : 4'd0;
            d_data   <= r_data;
            d_denied <= r_den;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (d_ready) begin
            state    <= IDLE;
            d_valid  <= 1'b0;
            d_opcode <= 4'd0;
            d_data   <= 32'd0;
            d_denied <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_slave_mem.sv
// Scoreboard bench for tl_slave_mem (DEPTH=8, LATENCY=3); expectations
// follow TL_SLAVE_DENIED_EN when it is defined.
module tb_tl_slave_mem;

  localparam int DEPTH   = 8;
  localparam int LATENCY = 3;
`ifdef TL_SLAVE_DENIED_EN
  localparam bit DEN = 1'b1;
`else
  localparam bit DEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [3:0]  a_opcode = 4'd0;
  logic [3:0]  a_mask = 4'd0;
  logic [3:0]  a_address = 4'd0;
  logic [31:0] a_data = 32'd0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [3:0]  d_opcode;
  logic [31:0] d_data;
  logic        d_denied;

  tl_slave_mem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_mask(a_mask), .a_address(a_address), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_data(d_data), .d_denied(d_denied)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
    logic        den;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rise_cyc = 0;
  logic prev_dv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per D handshake.
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      if (d_valid && !prev_dv) rise_cyc = cyc;
      if (d_valid && d_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=%h expected=none", d_data);
        end else begin
          e = exp_q.pop_front();
          chk("d_opcode", 32'(d_opcode), 32'(e.op));
          chk("d_data", d_data, e.data);
          chk("d_denied", 32'(d_denied), 32'(e.den));
        end
      end
    end
    prev_dv = d_valid;
  end

  task automatic send(input logic [3:0] op, input logic [3:0] mask, input logic [3:0] addr,
                      input logic [31:0] data, input bit expect_resp,
                      input logic [3:0] eop, input logic [31:0] edata, input logic eden);
    resp_t e;
    bit ok = 0;
    if (expect_resp) begin
      e.op = eop; e.data = edata; e.den = eden;
      exp_q.push_back(e);
    end
    a_opcode = op; a_mask = mask; a_address = addr; a_data = data;
    a_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a_ready) begin ok = 1; acc_cyc = cyc; break; end
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && a_ready && !d_valid) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_opcode", 32'(d_opcode), 32'd0);
    chk("rst_d_data", d_data, 32'd0);
    chk("rst_d_denied", 32'(d_denied), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;

    // Full put (mask ignored), then read back; Get latency measured.
    send(4'd0, 4'b0000, 4'd3, 32'hDEADBEEF, 1, 4'd0, 32'd0, 1'b0);
    send(4'd4, 4'b1111, 4'd3, 32'd0, 1, 4'd1, 32'hDEADBEEF, 1'b0);
    wait_idle();
    chk("get_latency", 32'(rise_cyc - acc_cyc), 32'(LATENCY + 1));

    // Partial put
    send(4'd1, 4'b0101, 4'd3, 32'h11223344, 1, 4'd0, 32'd0, 1'b0);
    send(4'd4, 4'b0000, 4'd3, 32'd0, 1, 4'd1, 32'hDE22BE44, 1'b0);
    wait_idle();

    // Response held with d_ready low; A traffic during hold ignored.
    d_ready = 1'b0;
    send(4'd4, 4'b0000, 4'd3, 32'd0, 1, 4'd1, 32'hDE22BE44, 1'b0);
    begin
      bit seen = 0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (d_valid) begin seen = 1; break; end
      end
      if (!seen) chk("hold_dvalid_timeout", 32'd0, 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_d_valid", 32'(d_valid), 32'd1);
      chk("hold_d_data", d_data, 32'hDE22BE44);
      chk("hold_a_ready", 32'(a_ready), 32'd0);
      if (k == 2) begin
        a_opcode = 4'd0; a_address = 4'd3; a_data = 32'hFFFFFFFF; a_valid = 1'b1;
      end
      if (k == 5) a_valid = 1'b0;
    end
    @(posedge clk); #1;
    d_ready = 1'b1;
    wait_idle();
    send(4'd4, 4'b0000, 4'd3, 32'd0, 1, 4'd1, 32'hDE22BE44, 1'b0);
    wait_idle();

    // Reset while BUSY after a put: no response, memory cleared.
    send(4'd0, 4'b1111, 4'd5, 32'h12345678, 0, 4'd0, 32'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_d_valid", 32'(d_valid), 32'd0);
    chk("abort_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    send(4'd4, 4'b0000, 4'd3, 32'd0, 1, 4'd1, 32'd0, 1'b0);
    send(4'd4, 4'b0000, 4'd5, 32'd0, 1, 4'd1, 32'd0, 1'b0);
    wait_idle();

    // Out-of-range address, unknown opcode, empty partial mask.
    send(4'd0, 4'b1111, 4'd9, 32'd5, 1, 4'd0, 32'd0, DEN);
    send(4'd4, 4'b0000, 4'd1, 32'd0, 1, 4'd1, DEN ? 32'd0 : 32'd5, 1'b0);
    send(4'd4, 4'b0000, 4'd9, 32'd0, 1, 4'd1, DEN ? 32'd0 : 32'd5, DEN);
    send(4'd2, 4'b1111, 4'd0, 32'hAAAAAAAA, 1, 4'd0, 32'd0, DEN);
    send(4'd4, 4'b0000, 4'd0, 32'd0, 1, 4'd1, 32'd0, 1'b0);
    send(4'd1, 4'b0000, 4'd1, 32'hFFFFFFFF, 1, 4'd0, 32'd0, 1'b0);
    send(4'd4, 4'b0000, 4'd1, 32'd0, 1, 4'd1, DEN ? 32'd0 : 32'd5, 1'b0);
    wait_idle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
